lsu_mem_port: RTL and testbench

Load/store unit that sits between the hart's memory stage and a variable-latency data memory, replacing the combinational single-cycle dmem port. It accepts one load or store per handshake, generates the aligned address, byte mask and lane-shifted write data, waits for the memory, then sign- or zero-extends load data. Misaligned or illegal accesses are trapped without touching memory, and a parametrised watchdog traps memories that never respond. Only one access is outstanding at a time.

---
 rtl/lsu_mem_port.sv | 247 ++++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between the memory stage and a variable-latency
// data memory. It accepts one access per handshake and drives a registered
// word-aligned strobe with a byte mask and lane-shifted store data. Load data
// is sign- or zero-extended. Misaligned and illegal accesses trap without a
// memory strobe. An optional watchdog traps a memory that never responds.
//
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_req_* / o_req_ready       request handshake (ready only while idle)
//   o_rsp_* / i_rsp_ready       response, held until taken
//   o_mem_* / i_mem_*           data-memory strobe, address, mask and read data
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_trap,
  output logic [1:0]        o_rsp_cause,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES > 0);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;
  localparam logic [1:0] CAUSE_ILL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_trap_q, rsp_trap_d;
  logic [1:0]        rsp_cause_q, rsp_cause_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic              accept_c;
  logic [1:0]        off_in_c;
  logic              misaligned_c;
  logic              wd_hit_c;
  logic [31:0]       ld_shift_c;
  logic [31:0]       ld_data_c;

  assign accept_c     = i_req_valid & req_ready_q;
  assign off_in_c     = i_req_addr[1:0];
  assign misaligned_c = ((i_req_size == 2'b01) && off_in_c[0]) ||
                        ((i_req_size == 2'b10) && (off_in_c != 2'b00));
  // Fires in the last allowed ISSUE/WAIT cycle; completion in that cycle still wins.
  assign wd_hit_c     = WD_EN && (wd_cnt_q == CNT_W'(WD_LAST));

  // Align the addressed lane to bit 0, then extend to 32 bits.
  assign ld_shift_c = i_mem_rdata >> {off_q, 3'b000};
  always_comb begin
    ld_data_c = ld_shift_c;
    case (size_q)
      2'b00:   ld_data_c = uns_q ? {24'h0, ld_shift_c[7:0]}
                                 : {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      2'b01:   ld_data_c = uns_q ? {16'h0, ld_shift_c[15:0]}
                                 : {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      default: ld_data_c = ld_shift_c;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    wen_d       = wen_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    rsp_valid_d = rsp_valid_q;
    rsp_trap_d  = rsp_trap_q;
    rsp_cause_d = rsp_cause_q;
    rsp_rdata_d = rsp_rdata_q;
    wd_cnt_d    = wd_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          wen_d       = i_req_wen;
          size_d      = i_req_size;
          uns_d       = i_req_unsigned;
          off_d       = off_in_c;
          wd_cnt_d    = '0;
          req_ready_d = 1'b0;
          if (i_req_size == 2'b11 || misaligned_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_trap_d  = 1'b1;
            rsp_cause_d = (i_req_size == 2'b11) ? CAUSE_ILL : CAUSE_MIS;
            rsp_rdata_d = '0;
          end else begin
            state_d     = S_ISSUE;
            mem_ren_d   = ~i_req_wen;
            mem_wen_d   = i_req_wen;
            mem_addr_d  = {i_req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = i_req_wdata << {off_in_c, 3'b000};
            case (i_req_size)
              2'b00:   mem_mask_d = 4'b0001 << off_in_c;
              2'b01:   mem_mask_d = 4'b0011 << off_in_c;
              default: mem_mask_d = 4'b1111;
            endcase
          end
        end
      end
      S_ISSUE: begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
        if (i_mem_ready) begin
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          if (wen_q) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_trap_d  = 1'b0;
            rsp_cause_d = CAUSE_NONE;
            rsp_rdata_d = '0;
          end else begin
            state_d = S_WAIT;
          end
        end else if (wd_hit_c) begin
          mem_ren_d   = 1'b0;
          mem_wen_d   = 1'b0;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_trap_d  = 1'b1;
          rsp_cause_d = CAUSE_TMO;
          rsp_rdata_d = '0;
        end
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
        if (i_mem_rvalid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_trap_d  = 1'b0;
          rsp_cause_d = CAUSE_NONE;
          rsp_rdata_d = ld_data_c;
        end else if (wd_hit_c) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_trap_d  = 1'b1;
          rsp_cause_d = CAUSE_TMO;
          rsp_rdata_d = '0;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_trap_d  = 1'b0;
          rsp_cause_d = CAUSE_NONE;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any access and drops strobes at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      wen_q       <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_trap_q  <= 1'b0;
      rsp_cause_q <= CAUSE_NONE;
      rsp_rdata_q <= '0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_trap_q  <= rsp_trap_d;
      rsp_cause_q <= rsp_cause_d;
      rsp_rdata_q <= rsp_rdata_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_trap  = rsp_trap_q;
  assign o_rsp_cause = rsp_cause_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_ren   = mem_ren_q;
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_mask  = mem_mask_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: runs a watchdog-enabled instance (TIMEOUT_CYCLES=4)
// and a watchdog-free instance (TIMEOUT_CYCLES=0) side by side on the same stimulus,
// checked cycle by cycle against an access-level timing/data model.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wen, req_unsigned, rsp_ready;
  logic        mem_ready, mem_rvalid;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [1:0]  req_size;

  logic [1:0]  req_ready, rsp_valid, rsp_trap, mem_ren, mem_wen;
  logic [1:0]  rsp_cause [2];
  logic [31:0] rsp_rdata [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_mask  [2];

  int n_assert;
  int n_fail;

  always #5 clk = ~clk;

  lsu_mem_port #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) u_dut_wd (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready[0]), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_size(req_size),
    .i_req_unsigned(req_unsigned),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata[0]),
    .o_rsp_trap(rsp_trap[0]), .o_rsp_cause(rsp_cause[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_ren(mem_ren[0]), .o_mem_wen(mem_wen[0]),
    .o_mem_wdata(mem_wdata[0]), .o_mem_mask(mem_mask[0]),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  lsu_mem_port #(.TIMEOUT_CYCLES(0), .ADDR_W(32)) u_dut_nowd (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready[1]), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_size(req_size),
    .i_req_unsigned(req_unsigned),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata[1]),
    .o_rsp_trap(rsp_trap[1]), .o_rsp_cause(rsp_cause[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_ren(mem_ren[1]), .o_mem_wen(mem_wen[1]),
    .o_mem_wdata(mem_wdata[1]), .o_mem_mask(mem_mask[1]),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid = 1'b0; req_wen = 1'b0; req_unsigned = 1'b0; req_size = 2'b00;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string name, input bit with_ready);
    for (int d = 0; d < 2; d++) begin
      if (with_ready) chk($sformatf("%s d%0d req_ready", name, d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("%s d%0d rsp_valid", name, d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("%s d%0d rsp_trap", name, d), 32'(rsp_trap[d]), 32'd0);
      chk($sformatf("%s d%0d rsp_cause", name, d), 32'(rsp_cause[d]), 32'd0);
      chk($sformatf("%s d%0d rsp_rdata", name, d), rsp_rdata[d], 32'd0);
      chk($sformatf("%s d%0d mem_ren", name, d), 32'(mem_ren[d]), 32'd0);
      chk($sformatf("%s d%0d mem_wen", name, d), 32'(mem_wen[d]), 32'd0);
      chk($sformatf("%s d%0d mem_addr", name, d), mem_addr[d], 32'd0);
      chk($sformatf("%s d%0d mem_wdata", name, d), mem_wdata[d], 32'd0);
      chk($sformatf("%s d%0d mem_mask", name, d), 32'(mem_mask[d]), 32'd0);
    end
  endtask

  // One access. rd: cycles the memory withholds ready; vd: extra cycles before
  // read data; hold: cycles rsp_ready stays low once the response is up.
  // Timing is counted in cycles after the accepting edge (cycle 1 = first issue cycle).
  task automatic run_access(input string name, input bit wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                            input int rd, input int vd, input logic [31:0] mword, input int hold);
    logic [1:0]  off;
    logic [1:0]  tcause;
    bit          trap;
    logic [3:0]  emask;
    logic [31:0] ewdata, eaddr, sh, ldv;
    int          c_r, c_done, c_take, c_end, tlim;
    int          cv [2];
    int          sl [2];
    bit          tmo [2];
    logic [31:0] e_rd [2];
    logic [31:0] e_tr [2];
    logic [31:0] e_ca [2];
    bit          ren_e, wen_e, vld_e, rdy_e;

    off    = addr[1:0];
    tcause = 2'd0;
    if (size == 2'd3) tcause = 2'd3;
    else if ((size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0)) tcause = 2'd1;
    trap   = (tcause != 2'd0);
    emask  = (size == 2'd0) ? 4'(1 << off) : (size == 2'd1) ? 4'(3 << off) : 4'hF;
    ewdata = wdata << (8 * off);
    eaddr  = addr & 32'hFFFF_FFFC;
    sh     = mword >> (8 * off);
    case (size)
      2'd0:    ldv = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    ldv = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ldv = sh;
    endcase

    c_r    = 1 + rd;
    c_done = wen ? c_r : c_r + 1 + vd;
    for (int d = 0; d < 2; d++) begin
      tlim = (d == 0) ? 4 : 0;
      tmo[d] = 1'b0;
      if (trap) begin
        cv[d] = 1; sl[d] = 0;
        e_rd[d] = 0; e_tr[d] = 1; e_ca[d] = 32'(tcause);
      end else if (tlim > 0 && c_done > tlim) begin
        tmo[d] = 1'b1; cv[d] = tlim + 1; sl[d] = (c_r < tlim) ? c_r : tlim;
        e_rd[d] = 0; e_tr[d] = 1; e_ca[d] = 2;
      end else begin
        cv[d] = c_done + 1; sl[d] = c_r;
        e_rd[d] = wen ? 32'd0 : ldv; e_tr[d] = 0; e_ca[d] = 0;
      end
    end
    c_take = cv[0] + hold;
    c_end  = c_take + 1;

    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s d%0d req_ready pre", name, d), 32'(req_ready[d]), 32'd1);
    @(posedge clk);

    for (int c = 1; c <= c_end; c++) begin
      #1;
      req_valid  = 1'b0;
      mem_ready  = (c == c_r);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!wen && c == c_done) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mword;
      end else if (c < c_r && $urandom_range(0, 1) == 1) begin
        mem_rvalid = 1'b1;
      end
      rsp_ready = (c == c_take);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ren_e = !trap && !wen && c <= sl[d];
        wen_e = !trap && wen && c <= sl[d];
        chk($sformatf("%s d%0d c%0d mem_ren", name, d, c), 32'(mem_ren[d]), 32'(ren_e));
        chk($sformatf("%s d%0d c%0d mem_wen", name, d, c), 32'(mem_wen[d]), 32'(wen_e));
        if (ren_e || wen_e) begin
          chk($sformatf("%s d%0d c%0d mem_addr", name, d, c), mem_addr[d], eaddr);
          chk($sformatf("%s d%0d c%0d mem_mask", name, d, c), 32'(mem_mask[d]), 32'(emask));
          if (wen) chk($sformatf("%s d%0d c%0d mem_wdata", name, d, c), mem_wdata[d], ewdata);
        end
        vld_e = (c >= cv[d]) && !(cv[d] <= c_take && c > c_take);
        chk($sformatf("%s d%0d c%0d rsp_valid", name, d, c), 32'(rsp_valid[d]), 32'(vld_e));
        if (vld_e) begin
          chk($sformatf("%s d%0d c%0d rsp_rdata", name, d, c), rsp_rdata[d], e_rd[d]);
          chk($sformatf("%s d%0d c%0d rsp_trap", name, d, c), 32'(rsp_trap[d]), e_tr[d]);
          chk($sformatf("%s d%0d c%0d rsp_cause", name, d, c), 32'(rsp_cause[d]), e_ca[d]);
        end
        rdy_e = (c == c_end) && (cv[d] <= c_take);
        chk($sformatf("%s d%0d c%0d req_ready", name, d, c), 32'(req_ready[d]), 32'(rdy_e));
      end
      if (c < c_end) @(posedge clk);
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0; rsp_ready = 1'b0;
    // The watchdog-free instance is still busy after a timeout; realign both.
    if (tmo[0]) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    n_assert = 0;
    n_fail   = 0;
    do_reset();
    check_reset_vals("reset", 1'b1);

    run_access("st_byte",   1'b1, 32'h0000_2003, 32'h0000_00AB, 2'd0, 1'b0, 0, 0, 32'h0, 0);
    run_access("ld_half_s", 1'b0, 32'h0000_1002, 32'h0,         2'd1, 1'b0, 0, 0, 32'h8001_1234, 0);
    run_access("ld_half_u", 1'b0, 32'h0000_1002, 32'h0,         2'd1, 1'b1, 0, 0, 32'h8001_1234, 0);
    run_access("ld_byte_s", 1'b0, 32'h0000_1001, 32'h0,         2'd0, 1'b0, 1, 1, 32'h1234_F678, 0);
    run_access("ld_word_mis", 1'b0, 32'h0000_1001, 32'h0,       2'd2, 1'b0, 0, 0, 32'hDEAD_BEEF, 0);
    run_access("st_half_mis", 1'b1, 32'h0000_1003, 32'h1234,    2'd1, 1'b0, 0, 0, 32'h0, 0);
    run_access("ld_illegal",  1'b0, 32'h0000_1000, 32'h0,       2'd3, 1'b0, 0, 0, 32'h0, 1);
    run_access("st_word",   1'b1, 32'h0000_5004, 32'hCAFE_F00D, 2'd2, 1'b0, 2, 0, 32'h0, 0);
    run_access("ld_tmo",    1'b0, 32'h0000_4000, 32'h0,         2'd2, 1'b0, 100, 0, 32'h0, 0);
    run_access("st_hold",   1'b1, 32'h0000_6002, 32'h0000_BEEF, 2'd1, 1'b0, 0, 0, 32'h0, 3);

    // Asynchronous reset while a load waits for read data.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_3000; req_size = 2'd2;
    req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_wait", 1'b0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_reset_vals("post_rst_stray", 1'b1);
    run_access("ld_after_rst", 1'b0, 32'h0000_3000, 32'h0, 2'd2, 1'b0, 0, 0, 32'h1357_9BDF, 0);

    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom, sz,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), $urandom, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
